// File: rtl/wb_spram_banked_pkg.sv
// Shared types and constants for the banked Wishbone SPRAM controller.
package spram_pkg;

    localparam int BANK_WORDS = 16384;
    localparam int BANK_AW    = 14;

    typedef enum logic [1:0] {
        IDLE,
        WAKE,
        ACK,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        AWAKE,
        SLEEPING,
        WAKING
    } pwr_e;

endpackage

// File: rtl/wb_spram_banked_if.sv
// Wishbone B3 classic bus bundle between a master and the SPRAM controller.
interface wb_spram_banked_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   wb_adr_i;
    logic [DW-1:0]   wb_dat_i;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_we_i;
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic            wb_ack_o;
    logic            wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40 UltraPlus 16Kx16 SPRAM primitive; leave this
// file out when the vendor cell library supplies the real primitive.
module SB_SPRAM256KA
    import spram_pkg::*;
(
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        CLOCK,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);
    logic [15:0] mem [BANK_WORDS];
    logic [15:0] bit_mask;
    logic        active;

    // Expand the nibble write mask to a per-bit mask.
    always_comb begin
        bit_mask = {{4{MASKWREN[3]}}, {4{MASKWREN[2]}}, {4{MASKWREN[1]}}, {4{MASKWREN[0]}}};
        active   = CHIPSELECT & ~SLEEP & ~STANDBY & POWEROFF;
    end

    // Synchronous masked write or registered read.
    always_ff @(posedge CLOCK) begin
        if (active) begin
            if (WREN) begin
                mem[ADDRESS] <= (mem[ADDRESS] & ~bit_mask) | (DATAIN & bit_mask);
            end else begin
                DATAOUT <= mem[ADDRESS];
            end
        end
    end
endmodule

// File: rtl/wb_spram_bank.sv
// One SPRAM bank: DW/16 primitives on a shared address, byte-lane masking and
// an idle/wake power manager that puts the bank to sleep after inactivity.
module wb_spram_bank
    import spram_pkg::*;
#(
    parameter int DW          = 32,
    parameter int IDLE_CYCLES = 1024,
    parameter int WAKE_CYCLES = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               acc_i,
    input  logic               we_i,
    input  logic               wake_i,
    input  logic [BANK_AW-1:0] adr_i,
    input  logic [DW-1:0]      dat_i,
    input  logic [DW/8-1:0]    sel_i,
    output logic [DW-1:0]      dat_o,
    output logic               awake_o,
    output logic               sleep_o
);
    localparam int NP = DW / 16;
    localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam int WW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;

    pwr_e          pwr_q, pwr_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [WW-1:0] wake_q, wake_d;
    logic          cs;

    assign cs      = acc_i & (pwr_q == AWAKE);
    assign awake_o = (pwr_q == AWAKE);
    assign sleep_o = (pwr_q == SLEEPING);

    // Power state and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwr_q  <= AWAKE;
            idle_q <= '0;
            wake_q <= '0;
        end else begin
            pwr_q  <= pwr_d;
            idle_q <= idle_d;
            wake_q <= wake_d;
        end
    end

    // Access beats the idle timeout in the same cycle; a wake always restarts the idle count.
    always_comb begin
        pwr_d  = pwr_q;
        idle_d = idle_q;
        wake_d = wake_q;
        case (pwr_q)
            AWAKE: begin
                if (acc_i) begin
                    idle_d = '0;
                end else if (IDLE_CYCLES != 0) begin
                    if (int'(idle_q) == IDLE_CYCLES - 1) begin
                        pwr_d  = SLEEPING;
                        idle_d = IW'(IDLE_CYCLES);
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            SLEEPING: begin
                if (wake_i) begin
                    idle_d = '0;
                    wake_d = '0;
                    pwr_d  = (WAKE_CYCLES == 0) ? AWAKE : WAKING;
                end
            end
            WAKING: begin
                if (int'(wake_q) == WAKE_CYCLES - 1) begin
                    pwr_d  = AWAKE;
                    wake_d = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: pwr_d = AWAKE;
        endcase
    end

    for (genvar h = 0; h < NP; h++) begin : g_spram
        SB_SPRAM256KA u_spram (
            .ADDRESS    (adr_i),
            .DATAIN     (dat_i[16*h +: 16]),
            .MASKWREN   ({sel_i[2*h+1], sel_i[2*h+1], sel_i[2*h], sel_i[2*h]}),
            .WREN       (cs & we_i),
            .CHIPSELECT (cs),
            .CLOCK      (clk_i),
            .STANDBY    (1'b0),
            .SLEEP      (sleep_o),
            .POWEROFF   (1'b1),
            .DATAOUT    (dat_o[16*h +: 16])
        );
    end
endmodule

// File: rtl/wb_spram_banked.sv
// Wishbone B3 classic slave over NBANKS power-managed SPRAM banks. Accesses to
// awake banks ack next cycle; sleeping banks are woken first.
module wb_spram_banked
    import spram_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int NBANKS      = 2,
    parameter int IDLE_CYCLES = 1024,
    parameter int WAKE_CYCLES = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_reset_i,
    wb_spram_banked_if.slave  wb,
    output logic [NBANKS-1:0] bank_sleep_o
);
    localparam int UW = AW - BANK_AW;

    if (!(DW == 16 || DW == 32) || !(NBANKS == 1 || NBANKS == 2 || NBANKS == 4) ||
        (NBANKS * DW / 16 > 4) || (AW < BANK_AW + 2) ||
        (IDLE_CYCLES < 0) || (WAKE_CYCLES < 0)) begin : g_bad_params
        $error("wb_spram_banked: illegal parameter combination");
    end

    state_e              state_q, state_d;
    logic [UW-1:0]       upper;
    logic                strobe, in_range;
    logic [1:0]          bank_live, bank_q, cur_bank, rbank_q;
    logic [BANK_AW-1:0]  adr_q, cur_adr;
    logic [DW-1:0]       dat_q, cur_dat;
    logic [DW/8-1:0]     sel_q, cur_sel;
    logic                we_q, cur_we;
    logic                latch, acc_req, wake_req;
    logic [3:0]          awake_a;
    logic [DW-1:0]       rdata_a [4];

    assign strobe    = wb.wb_cyc_i & wb.wb_stb_i;
    assign upper     = wb.wb_adr_i[AW-1:BANK_AW];
    assign bank_live = upper[1:0];
    assign in_range  = ((upper >> 2) == '0) && ({1'b0, upper[1:0]} < 3'(NBANKS));

    assign wb.wb_ack_o = (state_q == ACK);
    assign wb.wb_err_o = (state_q == ERR);
    assign wb.wb_dat_o = rdata_a[rbank_q];

    // FSM state, request latch and read-bank select registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            bank_q  <= '0;
            rbank_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                adr_q  <= wb.wb_adr_i[BANK_AW-1:0];
                dat_q  <= wb.wb_dat_i;
                sel_q  <= wb.wb_sel_i;
                we_q   <= wb.wb_we_i;
                bank_q <= bank_live;
            end
            if (acc_req && !cur_we) begin
                rbank_q <= cur_bank;
            end
        end
    end

    // Next state and access issue: IDLE drives the live bus straight through, WAKE replays the latched request.
    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        acc_req  = 1'b0;
        wake_req = 1'b0;
        cur_adr  = adr_q;
        cur_dat  = dat_q;
        cur_sel  = sel_q;
        cur_we   = we_q;
        cur_bank = bank_q;
        case (state_q)
            IDLE: begin
                cur_adr  = wb.wb_adr_i[BANK_AW-1:0];
                cur_dat  = wb.wb_dat_i;
                cur_sel  = wb.wb_sel_i;
                cur_we   = wb.wb_we_i;
                cur_bank = bank_live;
                if (strobe) begin
                    latch = 1'b1;
                    if (!in_range) begin
                        state_d = ERR;
                    end else if (awake_a[bank_live]) begin
                        acc_req = 1'b1;
                        state_d = ACK;
                    end else begin
                        wake_req = 1'b1;
                        state_d  = WAKE;
                    end
                end
            end
            WAKE: begin
                if (!wb.wb_cyc_i) begin
                    state_d = IDLE;
                end else if (awake_a[bank_q]) begin
                    acc_req = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wb_reset_i) begin
            acc_req  = 1'b0;
            wake_req = 1'b0;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        if (b < NBANKS) begin : g_real
            wb_spram_bank #(
                .DW          (DW),
                .IDLE_CYCLES (IDLE_CYCLES),
                .WAKE_CYCLES (WAKE_CYCLES)
            ) u_bank (
                .clk_i   (wb_clk_i),
                .rst_i   (wb_reset_i),
                .acc_i   (acc_req & (cur_bank == 2'(b))),
                .we_i    (cur_we),
                .wake_i  (wake_req & (bank_live == 2'(b))),
                .adr_i   (cur_adr),
                .dat_i   (cur_dat),
                .sel_i   (cur_sel),
                .dat_o   (rdata_a[b]),
                .awake_o (awake_a[b]),
                .sleep_o (bank_sleep_o[b])
            );
        end else begin : g_none
            assign rdata_a[b] = '0;
            assign awake_a[b] = 1'b0;
        end
    end
endmodule

// File: doc/wb_spram_banked.md
WB_SPRAM_BANKED -- requirements
Module: wb_spram_banked

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone word-address width.
REQ-002 SHALL have parameter DW, default 32, data width; legal values 16 or 32.
REQ-003 SHALL have parameter NBANKS, default 2, SPRAM banks; legal values 1, 2 or 4, with NBANKS*DW/16 <= 4.
REQ-004 SHALL have parameter IDLE_CYCLES, default 1024, idle cycles before a bank sleeps; 0 disables sleep.
REQ-005 SHALL have parameter WAKE_CYCLES, default 3, cycles a bank needs to leave SLEEP before access.
REQ-006 SHALL have port wb_clk_i  in  1  sole clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port wb_reset_i  in  1  synchronous, active-high reset.
REQ-008 SHALL have port wb_adr_i  in  AW  word address; [13:0] word in bank, [13+log2(NBANKS):14] bank index, higher bits must be zero.
REQ-009 SHALL have ports wb_dat_i in DW write data; wb_dat_o out DW read data; wb_sel_i in DW/8 byte lanes; wb_we_i in 1 write enable.
REQ-010 SHALL have ports wb_cyc_i in 1, wb_stb_i in 1, wb_ack_o out 1, wb_err_o out 1 (Wishbone B3 classic).
REQ-011 SHALL expose bank_sleep_o  out  NBANKS  per-bank sleep status.

Function
REQ-012 Each bank SHALL be DW/16 SB_SPRAM256KA primitives sharing address; byte lane n maps to MASKWREN nibble pair of its 16-bit half.
REQ-013 Controller FSM states SHALL be IDLE, WAKE, ACK, ERR.
REQ-014 IDLE: cyc&stb to out-of-range address (bank index >= NBANKS or upper bits nonzero) -> ERR; no SPRAM write, no CHIPSELECT.
REQ-015 IDLE: cyc&stb to awake bank -> access issued same cycle (CHIPSELECT, WREN=we for that bank only) -> ACK; wb_ack_o high next cycle, wb_dat_o valid with ack.
REQ-016 IDLE: cyc&stb to sleeping bank -> WAKE; SLEEP deasserted, counter runs WAKE_CYCLES cycles, then access issued, then ACK; ack latency WAKE_CYCLES+2 cycles from strobe.
REQ-017 ACK and ERR SHALL each last exactly one cycle, then IDLE; ack and err never asserted together; no back-to-back ack without strobe re-sampled in IDLE.
REQ-018 Address, data, sel, we SHALL be latched at strobe acceptance; changes during WAKE are ignored.
REQ-019 wb_cyc_i deasserted during WAKE SHALL abort: no write, no ack, FSM to IDLE; the bank completes waking and stays awake.
REQ-020 wb_dat_o SHALL be muxed by a registered bank index; it holds the last read bank's DATAOUT otherwise.
REQ-021 Per bank, an idle counter SHALL clear on any access and saturate at IDLE_CYCLES; reaching IDLE_CYCLES asserts SLEEP and bank_sleep_o bit; IDLE_CYCLES=0 never sleeps.
REQ-022 Strobe in the same cycle a bank's counter reaches IDLE_CYCLES SHALL win: bank stays awake, access per REQ-015.
REQ-023 STANDBY tied 0; POWEROFF tied 1 (no power-off; contents retained through sleep).

Reset
REQ-024 On wb_reset_i: FSM IDLE, wb_ack_o=0, wb_err_o=0, all banks awake, bank_sleep_o=0, idle and wake counters 0, bank index register 0.
REQ-025 Reset mid-transaction SHALL drop it with no ack/err and no write after the reset cycle; SPRAM contents are not cleared.

Structure
REQ-026 Package spram_pkg SHALL hold the FSM state enum, BANK_WORDS=16384, BANK_AW=14 and the per-bank power state enum (AWAKE, SLEEPING, WAKING).
REQ-027 Sub-module wb_spram_bank SHALL encapsulate one bank: SPRAM primitives, byte masking, idle/wake counters and power FSM; top instantiates NBANKS via generate.
REQ-028 Illegal parameter combinations SHALL fail elaboration.

Verification
REQ-029 Write 0xDEADBEEF, sel=4'b1111 to bank 0 word 5, read back -> ack 1 cycle after each strobe, read 0xDEADBEEF.
REQ-030 Write 0x11223344 then sel=4'b0010 with 0x0000AA00 to same word -> read 0x1122AA44.
REQ-031 NBANKS=2, access address 0x8000 (bank 2) -> wb_err_o one cycle, no ack, no SPRAM write, subsequent reads unchanged.
REQ-032 IDLE_CYCLES=16, WAKE_CYCLES=3: write bank 1, idle 16 cycles -> bank_sleep_o[1]=1; read it -> ack exactly 5 cycles after strobe, data intact.
REQ-033 Drop wb_cyc_i during WAKE of a write -> no ack, location retains old value.
REQ-034 Assert wb_reset_i during WAKE -> ack/err 0, bank_sleep_o=0 next cycle, no write.
